// File: rtl/movimiento_bus_master_if.sv
// Register-bus connection between movimiento_bus_master and the motion-control peripheral.
interface movimiento_bus_master_if;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] bus_d_out;
    logic [DW-1:0] bus_d_in;

    modport master (output cs, rd, wr, addr, bus_d_out, input  bus_d_in);
    modport slave  (input  cs, rd, wr, addr, bus_d_out, output bus_d_in);
endinterface

// File: rtl/movimiento_bus_master.sv
// Writes four latched setpoints plus the GO word to the motion-control peripheral.
// Define MOV_POLL_EN to also poll the status register until motion completes.
module movimiento_bus_master #(
    parameter int unsigned HOLD      = 2,
    parameter int unsigned MAX_POLLS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            rv1,
    input  logic [15:0]            rv2,
    input  logic [15:0]            rh1,
    input  logic [15:0]            rh2,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    movimiento_bus_master_if.master bus
);
    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 4;
    localparam int unsigned HW       = 4;
    localparam int unsigned IW       = 3;
    localparam int unsigned LAST_IDX = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ACT, S_WR_GAP, S_RD_ACT, S_RD_GAP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [3:0][DW-1:0]  sp_q, sp_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       dout_q, dout_d;

`ifdef MOV_POLL_EN
    localparam int unsigned PW = $clog2(MAX_POLLS + 1);
    logic [PW-1:0] poll_q, poll_d;
    logic          rd_q, rd_d;
    logic          error_q, error_d;
    logic          timeout_c;
`else
    localparam int unsigned UNUSED_MAX_POLLS = MAX_POLLS;
    logic unused_bus_d_in;
    assign unused_bus_d_in = ^bus.bus_d_in;
`endif

    // Next state, then outputs decoded from the state being entered so they are registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        sp_d    = sp_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        dout_d  = '0;
`ifdef MOV_POLL_EN
        poll_d    = poll_q;
        rd_d      = 1'b0;
        error_d   = 1'b0;
        timeout_c = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR_ACT;
                    idx_d   = '0;
                    hold_d  = '0;
                    sp_d    = {rh2, rh1, rv2, rv1};
                end
            end
            S_WR_ACT: begin
                if (hold_q == HW'(HOLD - 1)) state_d = S_WR_GAP;
                else                         hold_d  = hold_q + HW'(1);
            end
            S_WR_GAP: begin
                if (idx_q != IW'(LAST_IDX)) begin
                    state_d = S_WR_ACT;
                    idx_d   = idx_q + IW'(1);
                    hold_d  = '0;
                end else begin
`ifdef MOV_POLL_EN
                    state_d = S_RD_ACT;
                    hold_d  = '0;
                    poll_d  = '0;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MOV_POLL_EN
            S_RD_ACT: begin
                // Status is only judged on the final edge of the read window.
                if (hold_q == HW'(HOLD - 1)) begin
                    if (bus.bus_d_in[0]) begin
                        state_d = S_DONE;
                    end else if (poll_q == PW'(MAX_POLLS - 1)) begin
                        state_d   = S_DONE;
                        timeout_c = 1'b1;
                    end else begin
                        state_d = S_RD_GAP;
                        poll_d  = poll_q + PW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RD_GAP: begin
                state_d = S_RD_ACT;
                hold_d  = '0;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_WR_ACT: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                case (idx_d)
                    3'd0:    begin addr_d = 4'h2; dout_d = sp_d[0]; end
                    3'd1:    begin addr_d = 4'h4; dout_d = sp_d[1]; end
                    3'd2:    begin addr_d = 4'h6; dout_d = sp_d[2]; end
                    3'd3:    begin addr_d = 4'h8; dout_d = sp_d[3]; end
                    default: begin addr_d = 4'h0; dout_d = 16'h0001; end
                endcase
            end
            S_WR_GAP: busy_d = 1'b1;
`ifdef MOV_POLL_EN
            S_RD_ACT: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                rd_d   = 1'b1;
                addr_d = 4'hA;
            end
            S_RD_GAP: busy_d = 1'b1;
`endif
            S_DONE: begin
                done_d = 1'b1;
`ifdef MOV_POLL_EN
                error_d = timeout_c;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            sp_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
`ifdef MOV_POLL_EN
            poll_q  <= '0;
            rd_q    <= 1'b0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            sp_q    <= sp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
`ifdef MOV_POLL_EN
            poll_q  <= poll_d;
            rd_q    <= rd_d;
            error_q <= error_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.cs        = cs_q;
    assign bus.wr        = wr_q;
    assign bus.addr      = addr_q;
    assign bus.bus_d_out = dout_q;
`ifdef MOV_POLL_EN
    assign bus.rd = rd_q;
    assign error  = error_q;
`else
    assign bus.rd = 1'b0;
    assign error  = 1'b0;
`endif
endmodule

// File: doc/movimiento_bus_master.md
# movimiento_bus_master

Bus initiator that programs the motion-control peripheral over its memory-mapped register bus (cs/addr/rd/wr/16-bit data). On a start pulse it latches four 16-bit setpoints (RV1, RV2, RH1, RH2) and writes them in a fixed sequence. It then writes the peripheral's control register to launch motion and, optionally, polls a status register until motion completes. It sits between the system controller and the motion-control peripheral and replaces hand-sequenced bus writes.

## Interface
- HOLD, 2: cycles each bus access holds cs with rd or wr asserted (legal range 1..15).
- MAX_POLLS, 16: status reads attempted before timeout (used only with polling compiled in).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- rv1, rv2, rh1, rh2  in  16 each  setpoints, latched on the edge that accepts start.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle timeout pulse, coincident with done.
- cs  out  1  peripheral chip select.
- addr  out  4  peripheral register address.
- rd  out  1  read strobe.
- wr  out  1  write strobe.
- bus_d_out  out  16  write data to the peripheral's d_in.
- bus_d_in  in  16  read data from the peripheral's d_out.

## Operation
- States:
  - IDLE.
  - WR_ACT: cs=1, wr=1 for HOLD cycles.
  - WR_GAP: 1 cycle, cs=0.
  - RD_ACT: cs=1, rd=1 for HOLD cycles (polling only).
  - RD_GAP: 1 cycle (polling only).
  - DONE: 1 cycle.
- Write sequence, by index 0..4:
  - addr 4'h2, data rv1.
  - addr 4'h4, data rv2.
  - addr 4'h6, data rh1.
  - addr 4'h8, data rh2.
  - addr 4'h0, data 16'h0001 (control register, GO bit).
- Transitions:
  - IDLE→WR_ACT when start=1.
  - WR_ACT→WR_GAP when the hold counter reaches HOLD-1.
  - WR_GAP→WR_ACT (next index) while index<4.
  - After index 4: WR_GAP→DONE without polling, or WR_GAP→RD_ACT with polling.
  - DONE→IDLE.
- Bus signals:
  - addr and bus_d_out are stable for the whole active window.
  - addr and bus_d_out are driven to 0 whenever cs=0.
  - rd and wr are never both 1.
- start is ignored unless the state is IDLE, including while busy and in DONE.
- Setpoint inputs may change freely after acceptance; only latched copies are used.
- Reset:
  - Every output goes to 0 immediately: cs, rd, wr, addr, bus_d_out, busy, done, error.
  - The FSM goes to IDLE and the index, hold and poll counters clear.
  - A sequence in flight is abandoned and never resumed.

## Timing
- Accepting edge is cycle 0. busy=1 from cycle 1 through the last gap cycle. busy=0 in DONE.
- Write k is active in cycles 1+(HOLD+1)k through HOLD+(HOLD+1)k. Its gap cycle follows immediately.
- Without polling, done=1 at cycle 5(HOLD+1)+1. That is cycle 16 for HOLD=2. A new start is accepted no earlier than cycle 17.
- Polling:
  - bus_d_in is sampled on the last RD_ACT edge.
  - If bit 0 is 1, the FSM goes RD_ACT→DONE directly, with no gap.
  - Otherwise it goes RD_ACT→RD_GAP→RD_ACT, and the poll counter increments.
  - When the MAX_POLLS-th read returns bit 0 = 0, the FSM enters DONE with done=1 and error=1.

## Configuration
- MOV_POLL_EN:
  - Defined: after the GO write, the block reads addr 4'hA until bit 0 = 1 or MAX_POLLS reads have completed, as described above.
  - Undefined: no read logic is built. rd is tied to 0, bus_d_in is unused, error is tied to 0, and done follows the GO write's gap cycle.

## Test plan
- Reset mid-sequence: assert rst during write 2 → all outputs are 0 in the same cycle. After release, state is IDLE and no residual writes occur.
- Basic write (HOLD=2, no poll): start with rv1=10, rv2=15, rh1=11, rh2=20 → writes (2,10), (4,15), (6,11), (8,20), (0,1), each with cs=wr=1 for 2 cycles plus a 1-cycle gap. done is high at cycle 16 only.
- Start while busy: pulse start at cycles 5 and 16 → no extra writes and no second done. Latched values are unchanged when the inputs change after cycle 0.
- HOLD=1: same stimulus → each write is 1 cycle wide and done is at cycle 11.
- Poll success (MOV_POLL_EN, HOLD=2): status reads 0x0000 twice, then 0x0001 → 3 reads at addr 4'hA. done=1 and error=0 on the cycle after the third read.
- Poll timeout (MOV_POLL_EN, MAX_POLLS=4): status stays 0x0000 → exactly 4 reads, then done=1 and error=1 for one cycle. busy=0 afterward.
